// File: rtl/dct8_addr_gen_pkg.sv
// Shared constants, read-offset patterns and the write-request record for the
// 8-point DCT address generator.
package dct8_addr_gen_pkg;
  localparam int DCT8_N     = 8;
  localparam int NUM_STAGES = 4;
  localparam int IDX_W      = 3;
  localparam int STG_W      = 2;

  // Element [i] is the read offset used at index i.
  localparam logic [DCT8_N-1:0][IDX_W-1:0] RD_PAT_S0 =
    {3'd4, 3'd3, 3'd5, 3'd2, 3'd6, 3'd1, 3'd7, 3'd0};
  localparam logic [DCT8_N-1:0][IDX_W-1:0] RD_PAT_S1 =
    {3'd6, 3'd5, 3'd7, 3'd4, 3'd2, 3'd1, 3'd3, 3'd0};
  localparam logic [DCT8_N-1:0][IDX_W-1:0] RD_PAT_S2 =
    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [DCT8_N-1:0][IDX_W-1:0] RD_PAT_S3 =
    {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};

  typedef struct packed {
    logic             bank;
    logic [IDX_W-1:0] addr;
    logic             last;
  } wr_req_t;

  function automatic logic [IDX_W-1:0] rd_offset(input logic [STG_W-1:0] stage,
                                                 input logic [IDX_W-1:0] index);
    case (stage)
      2'd0:    rd_offset = RD_PAT_S0[index];
      2'd1:    rd_offset = RD_PAT_S1[index];
      2'd2:    rd_offset = RD_PAT_S2[index];
      default: rd_offset = RD_PAT_S3[index];
    endcase
  endfunction
endpackage

// File: rtl/dct8_delay_line.sv
// Fixed-depth shift register with reset-cleared valid; every stage is exposed
// so the caller can see all in-flight entries.
module dct8_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  input  logic [W-1:0]              in_data,
  output logic [DEPTH-1:0]          tap_vld,
  output logic [DEPTH-1:0][W-1:0]   tap_data
);
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      dat_pipe[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign tap_vld  = vld_pipe;
  assign tap_data = dat_pipe;
endmodule

// File: rtl/dct8_addr_gen.sv
// Read/write/coefficient address generator for the ping-pong 8-point DCT,
// with write strobes delayed by the datapath latency and a sticky RAW flag.
module dct8_addr_gen
  import dct8_addr_gen_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             done,
  input  logic [STG_W-1:0] stage,
  input  logic [IDX_W-1:0] index,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [IDX_W-1:0] rd_addr,
  output logic [4:0]       coef_addr,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [IDX_W-1:0] wr_addr,
  output logic             xform_done,
  output logic             raw_err
);
  localparam int DEPTH = PIPE_LAT + 1;
  localparam int REQ_W = $bits(wr_req_t);

  logic                        issue;
  wr_req_t                     wr_in;
  wr_req_t                     wr_head;
  logic [DEPTH-1:0]            tap_vld;
  logic [DEPTH-1:0][REQ_W-1:0] tap_data;
  logic                        hit;
  logic                        raw_clr;

  // The controller's DONE cycle still shows busy; it must not issue.
  assign issue   = busy & ~done;
  assign raw_clr = issue & (stage == '0) & (index == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      coef_addr <= '0;
    end else begin
      rd_en     <= issue;
      rd_bank   <= issue & stage[0];
      rd_addr   <= issue ? rd_offset(stage, index) : '0;
      coef_addr <= issue ? {stage, index} : '0;
    end
  end

  always_comb begin
    wr_in      = '0;
    wr_in.bank = ~stage[0];
    wr_in.addr = index;
    wr_in.last = (stage == STG_W'(NUM_STAGES - 1)) && (index == IDX_W'(DCT8_N - 1));
  end

  dct8_delay_line #(.DEPTH(DEPTH), .W(REQ_W)) u_wr_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (issue),
    .in_data  (wr_in),
    .tap_vld  (tap_vld),
    .tap_data (tap_data)
  );

  assign wr_head    = wr_req_t'(tap_data[DEPTH-1]);
  assign wr_en      = tap_vld[DEPTH-1];
  assign wr_bank    = wr_en & wr_head.bank;
  assign wr_addr    = wr_en ? wr_head.addr : '0;
  assign xform_done = wr_en & wr_head.last;

  // Every tap holds a write that is issued but not yet past its strobe cycle;
  // the last tap is the one strobing right now.
  always_comb begin
    wr_req_t req;
    hit = 1'b0;
    req = '0;
    for (int k = 0; k < DEPTH; k++) begin
      req = wr_req_t'(tap_data[k]);
      if (tap_vld[k] && (req.bank == rd_bank) && (req.addr == rd_addr)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              raw_err <= 1'b0;
    else if (rd_en && hit)   raw_err <= 1'b1;
    else if (raw_clr)        raw_err <= 1'b0;
  end
endmodule

// File: tb/tb_dct8_addr_gen.sv
// Scoreboard bench: three latency variants share one controller stimulus; each
// issue predicts its read and write events, a negedge monitor checks them.
module tb_dct8_addr_gen;
  localparam int NI = 3;

  function automatic int lat_of(int g);
    case (g)
      0:       return 2;
      1:       return 6;
      default: return 0;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic [1:0] stage = '0;
  logic [2:0] index = '0;

  logic       rd_en [NI];
  logic       rd_bank [NI];
  logic [2:0] rd_addr [NI];
  logic [4:0] coef_addr [NI];
  logic       wr_en [NI];
  logic       wr_bank [NI];
  logic [2:0] wr_addr [NI];
  logic       xform_done [NI];
  logic       raw_err [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      dct8_addr_gen #(.PIPE_LAT(lat_of(g))) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .done       (done),
        .stage      (stage),
        .index      (index),
        .rd_en      (rd_en[g]),
        .rd_bank    (rd_bank[g]),
        .rd_addr    (rd_addr[g]),
        .coef_addr  (coef_addr[g]),
        .wr_en      (wr_en[g]),
        .wr_bank    (wr_bank[g]),
        .wr_addr    (wr_addr[g]),
        .xform_done (xform_done[g]),
        .raw_err    (raw_err[g])
      );
    end
  endgenerate

  typedef struct {
    int         t;
    logic       bank;
    logic [2:0] addr;
    logic [4:0] coef;
    logic       last;
  } ev_t;

  ev_t  rdq [NI][$];
  ev_t  wrq [NI][$];
  logic m_raw [NI];
  int   cyc = 0;
  logic iss_clr = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   p0 [8] = '{0, 7, 1, 6, 2, 5, 3, 4};
  int   p1 [8] = '{0, 3, 1, 2, 4, 7, 5, 6};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] exp_rd(int s, int i);
    logic [2:0] v;
    v = 3'(i);
    case (s)
      0:       return 3'(p0[i]);
      1:       return 3'(p1[i]);
      2:       return v;
      default: return {v[0], v[1], v[2]};
    endcase
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got %0d want %0d", nm, k, cyc, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic issue(int s, int i);
    ev_t e;
    @(posedge clk); #1;
    busy = 1'b1; done = 1'b0; stage = 2'(s); index = 3'(i);
    iss_clr = (s == 0 && i == 0);
    for (int k = 0; k < NI; k++) begin
      e.t = cyc + 1; e.bank = s[0]; e.addr = exp_rd(s, i);
      e.coef = 5'(s * 8 + i); e.last = 1'b0;
      rdq[k].push_back(e);
      e.t = cyc + 1 + lat_of(k); e.bank = ~s[0]; e.addr = 3'(i);
      e.coef = '0; e.last = (s == 3 && i == 7);
      wrq[k].push_back(e);
    end
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      busy = 1'b0; done = 1'b0; iss_clr = 1'b0;
      stage = 2'($urandom); index = 3'($urandom);
    end
  endtask

  task automatic done_cyc();
    @(posedge clk); #1;
    busy = 1'b1; done = 1'b1; stage = 2'd3; index = 3'd0; iss_clr = 1'b0;
  endtask

  // Runs a transform; a stop_at in 0..31 aborts it with reset at that issue.
  task automatic xform(int stop_at);
    for (int n = 0; n < 32; n++) begin
      if (n == stop_at) begin
        @(posedge clk); #1;
        rst_n = 1'b0; busy = 1'b0; done = 1'b0; iss_clr = 1'b0;
        idle(2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      issue(n / 8, n % 8);
    end
    done_cyc();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ev_t e;
    bit  rexp;
    bit  wexp;
    bit  hit;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        chk("rst_rd_en", k, rd_en[k], 0);
        chk("rst_rd_out", k, {rd_bank[k], rd_addr[k], coef_addr[k]}, 0);
        chk("rst_wr_out", k, {wr_en[k], wr_bank[k], wr_addr[k], xform_done[k]}, 0);
        chk("rst_raw_err", k, raw_err[k], 0);
        rdq[k].delete();
        wrq[k].delete();
        m_raw[k] = 1'b0;
      end else begin
        hit  = 1'b0;
        rexp = (rdq[k].size() > 0) && (rdq[k][0].t == cyc);
        chk("rd_en", k, rd_en[k], rexp);
        if (rexp) begin
          e = rdq[k].pop_front();
          chk("rd_bank", k, rd_bank[k], e.bank);
          chk("rd_addr", k, rd_addr[k], e.addr);
          chk("coef_addr", k, coef_addr[k], e.coef);
          // In flight: writes from earlier issues whose strobe is now or later.
          for (int j = 0; j < wrq[k].size(); j++)
            if (wrq[k][j].t >= cyc && wrq[k][j].t <= cyc + lat_of(k) &&
                wrq[k][j].bank == e.bank && wrq[k][j].addr == e.addr)
              hit = 1'b1;
        end
        wexp = (wrq[k].size() > 0) && (wrq[k][0].t == cyc);
        chk("wr_en", k, wr_en[k], wexp);
        if (wexp) begin
          e = wrq[k].pop_front();
          chk("wr_bank", k, wr_bank[k], e.bank);
          chk("wr_addr", k, wr_addr[k], e.addr);
          chk("xform_done", k, xform_done[k], e.last);
        end else begin
          chk("wr_idle", k, {wr_bank[k], wr_addr[k], xform_done[k]}, 0);
        end
        chk("raw_err", k, raw_err[k], m_raw[k]);
        if (hit)          m_raw[k] = 1'b1;
        else if (iss_clr) m_raw[k] = 1'b0;
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    for (int k = 0; k < NI; k++) m_raw[k] = 1'b0;
    idle(3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);
    xform(99);                     // single transform
    idle(6);
    xform(99); xform(99); xform(99); // back-to-back
    idle(10);
    xform(20);                     // reset during stage 2
    idle(2);
    xform(99);
    idle(9);
    for (int r = 0; r < 6; r++) begin
      idle($urandom_range(0, 3));
      xform(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 99);
    end
    idle(12);
    for (int k = 0; k < NI; k++) begin
      chk("rdq_drained", k, rdq[k].size(), 0);
      chk("wrq_drained", k, wrq[k].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
